// File: rtl/uart_cfg_regfile.sv
// rtl/uart_cfg_regfile.sv - framed, checksummed register file loaded over a UART byte stream
// Frames: HEADER CMD ADDR [DATA x NB] CHK; replies ACK/NAK or read data, with gap timeout recovery.
module uart_cfg_regfile #(
  parameter int                NUM_REGS    = 4,
  parameter int                DATA_W      = 8,
  parameter logic [7:0]        HEADER      = 8'hA5,
  parameter int                TIMEOUT_CYC = 100000,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       tx_busy,
  output logic [7:0]                 tx_data,
  output logic                       tx_trig,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        reg_wr,
  output logic [7:0]                 err_cnt
);
  localparam int         NB         = DATA_W / 8;
  localparam int         GAP_W      = $clog2(TIMEOUT_CYC + 1);
  localparam int         CNT_W      = $clog2(NB + 1);
  localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);
  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RESP} state_t;
  state_t r_state, w_next;

  logic [7:0]                 r_addr, r_chk, r_err, r_tx_data;
  logic                       r_is_wr, r_chk_ok;
  logic [DATA_W-1:0]          r_data, r_resp_buf, w_rd_val;
  logic [CNT_W-1:0]           r_byte_cnt, r_resp_left;
  logic [GAP_W-1:0]           r_gap;
  logic [1:0]                 r_guard;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic                       w_in_frame, w_timeout, w_exec_ok, w_err_inc, w_tx_fire;
  logic [7:0]                 w_tx_byte;
  logic [NUM_REGS-1:0]        w_reg_wr;

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_DATA) || (r_state == S_CHK);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_timeout  = w_in_frame && !rx_valid && (r_gap == GAP_W'(TIMEOUT_CYC - 1));
  assign w_exec_ok  = r_chk_ok && ({1'b0, r_addr} < NUM_REGS_L);
  assign w_tx_fire  = (r_state == S_RESP) && (r_guard == 2'd0) && !tx_busy;
  assign w_tx_byte  = r_resp_buf[DATA_W-1 -: 8];

  always_comb begin
    w_rd_val = '0;
    w_reg_wr = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_addr == 8'(k)) begin
        w_rd_val    = r_regs[k*DATA_W +: DATA_W];
        w_reg_wr[k] = (r_state == S_EXEC) && r_is_wr && w_exec_ok;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_inc = 1'b0;
    case (r_state)
      S_IDLE: if (rx_valid && rx_data == HEADER) w_next = S_CMD;
      S_CMD:
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            w_next = S_ADDR;
          end else begin
            w_next    = S_IDLE;
            w_err_inc = 1'b1;
          end
        end
      S_ADDR: if (rx_valid) w_next = r_is_wr ? S_DATA : S_CHK;
      S_DATA: if (rx_valid && r_byte_cnt == CNT_W'(NB - 1)) w_next = S_CHK;
      S_CHK:  if (rx_valid) w_next = S_EXEC;
      S_EXEC: begin
        w_next    = S_RESP;
        w_err_inc = !w_exec_ok;
      end
      S_RESP: if (w_tx_fire && r_resp_left == CNT_W'(1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_next    = S_IDLE;
      w_err_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_chk       <= '0;
      r_err       <= '0;
      r_tx_data   <= '0;
      r_is_wr     <= 1'b0;
      r_chk_ok    <= 1'b0;
      r_data      <= '0;
      r_resp_buf  <= '0;
      r_byte_cnt  <= '0;
      r_resp_left <= '0;
      r_gap       <= '0;
      r_guard     <= '0;
      r_regs      <= {NUM_REGS{RESET_VAL}};
    end else begin
      if (!w_in_frame || rx_valid) r_gap <= '0;
      else                         r_gap <= r_gap + GAP_W'(1);

      if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;

      if (rx_valid) begin
        case (r_state)
          S_CMD: begin
            r_is_wr <= (rx_data == CMD_WR);
            r_chk   <= rx_data;
          end
          S_ADDR: begin
            r_addr     <= rx_data;
            r_chk      <= r_chk ^ rx_data;
            r_byte_cnt <= '0;
          end
          S_DATA: begin
            r_data     <= (r_data << 8) | DATA_W'(rx_data);
            r_chk      <= r_chk ^ rx_data;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
          end
          S_CHK:   r_chk_ok <= (rx_data == r_chk);
          default: ;
        endcase
      end

      if (r_state == S_EXEC) begin
        for (int k = 0; k < NUM_REGS; k++)
          if (w_reg_wr[k]) r_regs[k*DATA_W +: DATA_W] <= r_data;
        if (!w_exec_ok) begin
          r_resp_buf  <= DATA_W'(NAK) << (DATA_W - 8);
          r_resp_left <= CNT_W'(1);
        end else if (r_is_wr) begin
          r_resp_buf  <= DATA_W'(ACK) << (DATA_W - 8);
          r_resp_left <= CNT_W'(1);
        end else begin
          r_resp_buf  <= w_rd_val;
          r_resp_left <= CNT_W'(NB);
        end
      end

      // Guard masks tx_busy for the two cycles after a trigger while uart_tx raises busy.
      if (w_tx_fire) begin
        r_tx_data   <= w_tx_byte;
        r_resp_buf  <= r_resp_buf << 8;
        r_resp_left <= r_resp_left - CNT_W'(1);
        r_guard     <= 2'd2;
      end else if (r_guard != 2'd0) begin
        r_guard <= r_guard - 2'd1;
      end
    end
  end

  assign tx_trig = w_tx_fire;
  assign tx_data = w_tx_fire ? w_tx_byte : r_tx_data;
  assign regs    = r_regs;
  assign reg_wr  = w_reg_wr;
  assign err_cnt = r_err;
endmodule

// File: tb/tb_uart_cfg_regfile.sv
// tb/tb_uart_cfg_regfile.sv - randomized frame-level checking of uart_cfg_regfile
module tb_uart_cfg_regfile;
  localparam int          NR  = 4;
  localparam int          DW  = 16;
  localparam int          NB  = 2;
  localparam int          T   = 20;
  localparam logic [7:0]  HDR = 8'hA5;
  localparam logic [DW-1:0] RV = 16'h5A3C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic tx_busy = 1'b0;
  logic [7:0] tx_data, err_cnt;
  logic tx_trig;
  logic [NR*DW-1:0] regs;
  logic [NR-1:0] reg_wr;

  uart_cfg_regfile #(.NUM_REGS(NR), .DATA_W(DW), .HEADER(HDR), .TIMEOUT_CYC(T), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_trig(tx_trig), .regs(regs), .reg_wr(reg_wr), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0, resp_start = 0, last_trig = -100;
  int busy_len_cfg = 3, busy_dly = 0, busy_rem = 0;
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_reg_wr = '0;
  logic [7:0] m_err = 8'h00, last_tx = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  int trig_cyc[$];
  bit trig_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic int rand_gap();
    return ($urandom_range(0, 7) == 0) ? T - 1 : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the frame-level model.
  always @(negedge clk) begin
    logic elig;
    for (int k = 0; k < NR; k++)
      check($sformatf("regs%0d", k), 32'(regs[k*DW +: DW]), 32'(m_regs[k]));
    check("reg_wr", 32'(reg_wr), 32'(m_reg_wr));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    elig = (exp_q.size() > 0) && (cyc >= resp_start) && (cyc >= last_trig + 3) && !tx_busy;
    check("tx_trig", 32'(tx_trig), 32'(elig));
    if (tx_trig) begin
      tx_log.push_back(tx_data);
      trig_cyc.push_back(cyc);
      if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      last_tx   = tx_data;
      last_trig = cyc;
      trig_flag = 1'b1;
    end else begin
      check("tx_hold", 32'(tx_data), 32'(last_tx));
    end
  end

  // uart_tx stand-in: busy rises three cycles after a trigger and stays up busy_len_cfg cycles.
  always @(posedge clk) begin
    #1;
    if (trig_flag) begin
      trig_flag = 1'b0;
      busy_dly  = 2;
    end else if (busy_dly > 0) begin
      busy_dly--;
      if (busy_dly == 0 && busy_len_cfg > 0) begin
        tx_busy  = 1'b1;
        busy_rem = busy_len_cfg;
      end
    end else if (tx_busy) begin
      busy_rem--;
      if (busy_rem == 0) tx_busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    for (int k = 0; k < NR; k++) m_regs[k] = RV;
    m_reg_wr   = '0;
    m_err      = 8'h00;
    last_tx    = 8'h00;
    last_trig  = -100;
    resp_start = 0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom_range(0, 255));
      if (v == HDR) v = 8'h00;
      send_byte(v, rand_gap());
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [DW-1:0] data,
                           input logic [7:0] chk_bad, input int abort_k);
    logic [7:0] b[$];
    logic [7:0] chk;
    bit ok, wr, valid_cmd;
    int w, ai;
    wr        = (cmd == 8'h01);
    valid_cmd = (cmd == 8'h01) || (cmd == 8'h02);
    ai        = int'(addr);
    b.push_back(HDR);
    b.push_back(cmd);
    if (valid_cmd) begin
      b.push_back(addr);
      chk = cmd ^ addr;
      if (wr) begin
        for (int i = NB - 1; i >= 0; i--) begin
          b.push_back(data[i*8 +: 8]);
          chk = chk ^ data[i*8 +: 8];
        end
      end
      b.push_back(chk ^ chk_bad);
    end
    if (abort_k > 0) begin
      for (int i = 0; i < abort_k; i++) send_byte(b[i], rand_gap());
      repeat (T - 1) tick();
      tick();
      m_err = sat(m_err);
      return;
    end
    foreach (b[i]) send_byte(b[i], rand_gap());
    if (!valid_cmd) begin
      m_err = sat(m_err);
      return;
    end
    ok = (chk_bad == 8'h00) && (ai < NR);
    if (wr && ok) m_reg_wr = NR'(1) << ai;
    if (!ok)     exp_q.push_back(8'h15);
    else if (wr) exp_q.push_back(8'h06);
    else for (int i = NB - 1; i >= 0; i--) exp_q.push_back(m_regs[ai][i*8 +: 8]);
    resp_start = cyc + 1;
    tick();
    m_reg_wr = '0;
    if (wr && ok) m_regs[ai] = data;
    if (!ok) m_err = sat(m_err);
    w = 0;
    while (exp_q.size() > 0 && w < 400) begin
      if ($urandom_range(0, 5) == 0) begin
        rx_data  = 8'($urandom_range(0, 255));
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      w++;
    end
    check("resp_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rs, len, k;
    logic [7:0] c, a;
    do_reset();
    check("lit_rst_err", 32'(err_cnt), 32'd0);
    check("lit_rst_reg2", 32'(regs[2*DW +: DW]), 32'(RV));

    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    run_frame(8'h01, 8'h00, 16'h1234, 8'h00, 0);
    rs = resp_start;
    check("lit_wr_reg0", 32'(regs[0 +: DW]), 32'h1234);
    check("lit_ack", 32'(tx_log[tx_log.size()-1]), 32'h06);
    check("lit_ack_latency", 32'(trig_cyc[trig_cyc.size()-1]), 32'(rs));
    check("lit_err0", 32'(err_cnt), 32'd0);

    busy_len_cfg = 100;
    run_frame(8'h02, 8'h00, 16'h0000, 8'h00, 0);
    busy_len_cfg = 3;
    check("lit_rd_hi", 32'(tx_log[tx_log.size()-2]), 32'h12);
    check("lit_rd_lo", 32'(tx_log[tx_log.size()-1]), 32'h34);
    check("lit_busy_gap", 32'(trig_cyc[trig_cyc.size()-1] - trig_cyc[trig_cyc.size()-2]), 32'd103);

    run_frame(8'h01, 8'h01, 16'h0055, 8'h01, 0);
    check("lit_nak", 32'(tx_log[tx_log.size()-1]), 32'h15);
    check("lit_err1", 32'(err_cnt), 32'd1);
    check("lit_badchk_reg1", 32'(regs[DW +: DW]), 32'(RV));
    run_frame(8'h01, 8'h04, 16'h0011, 8'h00, 0);
    check("lit_err2", 32'(err_cnt), 32'd2);
    run_frame(8'h01, 8'h03, 16'h0000, 8'h00, 3);
    check("lit_err3_timeout", 32'(err_cnt), 32'd3);
    run_frame(8'h01, 8'h03, 16'hAAAA, 8'h00, 0);
    check("lit_reg3", 32'(regs[3*DW +: DW]), 32'hAAAA);
    run_frame(8'h01, 8'h02, 16'hA5A5, 8'h00, 0);
    run_frame(8'h07, 8'h00, 16'h0000, 8'h00, 0);
    check("lit_err4_badcmd", 32'(err_cnt), 32'd4);

    send_byte(HDR, 0);
    send_byte(8'h01, 1);
    send_byte(8'h00, 0);
    send_byte(8'h12, 2);
    do_reset();
    check("lit_midrst_reg0", 32'(regs[0 +: DW]), 32'(RV));
    check("lit_midrst_err", 32'(err_cnt), 32'd0);
    send_garbage(2);
    run_frame(8'h01, 8'h01, 16'hBEEF, 8'h00, 0);
    check("lit_post_rst_reg1", 32'(regs[DW +: DW]), 32'hBEEF);

    for (int f = 0; f < 150; f++) begin
      busy_len_cfg = $urandom_range(0, 8);
      if ($urandom_range(0, 4) == 0) send_garbage($urandom_range(1, 3));
      k = $urandom_range(0, 9);
      if (k < 7)      c = 8'h01;
      else if (k < 9) c = 8'h02;
      else begin
        c = 8'($urandom_range(3, 255));
      end
      a = 8'($urandom_range(0, 5));
      len = (c == 8'h01) ? 3 + NB + 1 : 4;
      if (c != 8'h01 && c != 8'h02)
        run_frame(c, a, 16'h0, 8'h00, 0);
      else if ($urandom_range(0, 9) == 0)
        run_frame(c, a, DW'($urandom), 8'h00, $urandom_range(1, len - 1));
      else
        run_frame(c, a, DW'($urandom), ($urandom_range(0, 6) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 0);
    end

    for (int f = 0; f < 300; f++) run_frame(8'h00, 8'h00, 16'h0, 8'h00, 0);
    check("lit_err_sat", 32'(err_cnt), 32'd255);
    run_frame(8'h01, 8'h00, 16'h0001, 8'h01, 0);
    check("lit_err_sat_hold", 32'(err_cnt), 32'd255);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_cfg_regfile.md
Name: uart_cfg_regfile

Overview:
Framed, checksummed configuration register file driven by the UART byte stream. It replaces the unframed 4-byte threshold loader with addressed writes and reads over a generic register count and width. It adds error recovery: header resync, byte-gap timeout, ACK/NAK replies and an error counter. It sits between uart_rx/uart_tx and the image-processing threshold inputs.

Parameters:
NUM_REGS, 4, number of registers (1..255)
DATA_W, 8, register width in bits; multiple of 8, 8..32; NB = DATA_W/8 bytes per value
HEADER, 8'hA5, frame start byte
TIMEOUT_CYC, 100000, max clk cycles between bytes inside a frame (2 ms at 50 MHz)
RESET_VAL, 0, reset value of every register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte (uart_rx po_data)
rx_valid  in  1  one-cycle strobe, rx_data valid (uart_rx po_flag)
tx_busy  in  1  uart_tx busy; high while a byte is shifting out
tx_data  out  8  byte to transmit
tx_trig  out  1  one-cycle transmit request
regs  out  NUM_REGS*DATA_W  flat register bus; reg k at bits [k*DATA_W +: DATA_W]
reg_wr  out  NUM_REGS  one-cycle pulse on the bit of a register just written
err_cnt  out  8  saturating count of rejected or aborted frames

Behaviour:
- Reset values: regs = RESET_VAL; reg_wr, tx_trig, tx_data, err_cnt = 0; FSM in IDLE; all counters cleared. Reset mid-frame or mid-response aborts immediately with no partial register update.
- Write frame: HEADER, CMD=0x01, ADDR, NB data bytes (MSB first), CHK.
- Read frame: HEADER, CMD=0x02, ADDR, CHK.
- CHK is the XOR of CMD, ADDR and all data bytes. HEADER is excluded.
- States: IDLE, CMD, ADDR, DATA, CHK, EXEC, RESP.
  - IDLE: a byte equal to HEADER goes to CMD. Any other byte is discarded silently, with no error.
  - CMD: 0x01 or 0x02 goes to ADDR. Any other value goes to IDLE with err_cnt+1 and no reply.
  - ADDR: latch the address. A write goes to DATA; a read goes to CHK.
  - DATA: shift in NB bytes, then go to CHK.
  - CHK: compare the received byte with the running XOR, then go to EXEC.
  - EXEC (1 cycle):
    - Write, with checksum OK and ADDR < NUM_REGS: update the register, reg_wr[ADDR] = 1 for this cycle only, reply 0x06.
    - Write, otherwise: no update, err_cnt+1, reply 0x15.
    - Read, valid: reply the NB bytes of regs[ADDR], MSB first.
    - Read, invalid: err_cnt+1, reply 0x15.
  - RESP: send reply bytes, then return to IDLE.
- Register update becomes visible on regs the cycle after EXEC. Untouched registers hold their value.
- Timeout: in CMD, ADDR, DATA or CHK, a gap counter counts cycles since the last rx_valid and clears on each rx_valid. When it reaches TIMEOUT_CYC: go to IDLE, err_cnt+1, no reply, no update. The counter is idle in IDLE and RESP.
- TX handshake:
  - tx_trig pulses 1 cycle with tx_data held stable. tx_data keeps its value until the next trigger.
  - After a trigger, tx_busy is ignored for 2 cycles (guard for busy assertion latency).
  - The next byte is triggered on the first cycle after the guard where tx_busy = 0.
  - The first reply byte is issued the cycle after EXEC if tx_busy = 0.
- rx_valid during RESP: byte dropped, no error. Reception resumes in IDLE.
- HEADER appearing inside a frame is treated as ordinary data; there is no mid-frame resync except by timeout or checksum.
- err_cnt saturates at 255.
- rx_valid and a timeout in the same cycle: the byte wins and the gap counter clears.

Test Plan:
- DATA_W=8: send A5 01 02 3C 3F -> regs[2]=0x3C one cycle after EXEC; reg_wr=4'b0100 for one cycle; tx byte 0x06; err_cnt=0.
- Then send A5 02 02 00 -> tx byte 0x3C; regs unchanged; reg_wr stays 0.
- Bad checksum A5 01 01 55 00 -> regs[1] stays 0; tx 0x15; err_cnt=1. Out-of-range address A5 01 04 11 14 -> tx 0x15; err_cnt=2.
- Send A5 01 03, then idle for TIMEOUT_CYC cycles -> FSM in IDLE; err_cnt+1; no tx_trig. A following valid frame A5 01 03 AA A8 -> regs[3]=0xAA.
- DATA_W=16: A5 01 00 12 34 27 -> regs[0]=0x1234. Read A5 02 00 02 -> tx 0x12 then 0x34. Hold tx_busy high 100 cycles after the first trigger -> second trigger only after busy falls.
- Assert rst_n low after A5 01 00 12 (DATA_W=16) -> all regs=RESET_VAL; err_cnt=0. A later full frame is accepted normally. Garbage bytes 00 FF before A5 are ignored with no err_cnt change.
